// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer: cause codes, vector byte
// addresses, and the sequencer state encoding.
package exception_sequencer_pkg;

  localparam logic [1:0] EXC_OPCODE   = 2'd0;
  localparam logic [1:0] EXC_OVERFLOW = 2'd1;
  localparam logic [1:0] EXC_DIVZERO  = 2'd2;

  localparam logic [31:0] VEC_OPCODE   = 32'd253;
  localparam logic [31:0] VEC_OVERFLOW = 32'd254;
  localparam logic [31:0] VEC_DIVZERO  = 32'd255;

  typedef enum logic [1:0] {IDLE, SAVE, WAIT, LOAD} exc_state_t;

  // Vector byte address for a cause code; code 3 is never produced.
  function automatic logic [31:0] cause_to_vec(input logic [1:0] cause);
    unique case (cause)
      EXC_OPCODE:   cause_to_vec = VEC_OPCODE;
      EXC_OVERFLOW: cause_to_vec = VEC_OVERFLOW;
      default:      cause_to_vec = VEC_DIVZERO;
    endcase
  endfunction

endpackage

// File: rtl/exception_sequencer_exc_priority_encoder.sv
// Combinational priority encoder for exception flags.
// Ports:
//   exc_opcode_i, exc_overflow_i, exc_divzero_i : one-cycle flags
//   valid_o : any flag set
//   cause_o : winning cause (opcode > overflow > divzero), 0 when none
module exc_priority_encoder
  import exception_sequencer_pkg::*;
(
  input  logic       exc_opcode_i,
  input  logic       exc_overflow_i,
  input  logic       exc_divzero_i,
  output logic       valid_o,
  output logic [1:0] cause_o
);

  always_comb begin
    valid_o = exc_opcode_i | exc_overflow_i | exc_divzero_i;
    if (exc_opcode_i) begin
      cause_o = EXC_OPCODE;
    end else if (exc_overflow_i) begin
      cause_o = EXC_OVERFLOW;
    end else if (exc_divzero_i) begin
      cause_o = EXC_DIVZERO;
    end else begin
      cause_o = EXC_OPCODE;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception sequencer: latches the winning exception cause, saves EPC,
// fetches the handler byte through the vector address and loads it into PC.
// Ports:
//   clk, reset (async active-low)
//   exc_opcode/exc_overflow/exc_divzero : one-cycle exception flags
//   pc_in       : current (incremented) PC
//   mem_data_in : memory read data, byte [7:0] is handler address
//   exceptions_control : cause code to vector mapper
//   mem_vec_sel, mem_read : memory mux select and read strobe
//   epc_out/epc_write, pc_out/pc_write : register update values and strobes
//   busy : main FSM stall; double_fault : sticky, flag raised while busy
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned EPC_OFFSET  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [1:0]  exceptions_control,
  output logic        mem_vec_sel,
  output logic        mem_read,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] pc_out,
  output logic        pc_write,
  output logic        busy,
  output logic        double_fault
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

  exc_state_t      state_q, state_d;
  logic [1:0]      cause_q, cause_d;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            df_q, df_d;

  logic       flag_valid;
  logic [1:0] flag_cause;

  logic unused_mem_hi;
  assign unused_mem_hi = ^mem_data_in[31:8];

  exc_priority_encoder u_prio (
    .exc_opcode_i   (exc_opcode),
    .exc_overflow_i (exc_overflow),
    .exc_divzero_i  (exc_divzero),
    .valid_o        (flag_valid),
    .cause_o        (flag_cause)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    df_d    = df_q;

    unique case (state_q)
      IDLE: begin
        if (flag_valid) begin
          cause_d = flag_cause;
          epc_d   = pc_in - 32'(EPC_OFFSET);
          cnt_d   = CntW'(MEM_LATENCY);
          state_d = SAVE;
        end
      end
      SAVE: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        // Counter hits zero on this edge: memory data is valid now.
        if (cnt_q == CntW'(1)) begin
          pc_d    = {24'b0, mem_data_in[7:0]};
          state_d = LOAD;
        end
      end
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flags outside IDLE never start a sequence but are remembered.
    if (state_q != IDLE && flag_valid) begin
      df_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= EXC_OPCODE;
      epc_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      df_q    <= df_d;
    end
  end

  // Moore outputs; value outputs hold last register contents in IDLE.
  always_comb begin
    exceptions_control = cause_q;
    epc_out            = epc_q;
    pc_out             = pc_q;
    double_fault       = df_q;
    busy               = (state_q != IDLE);
    epc_write          = 1'b0;
    pc_write           = 1'b0;
    mem_vec_sel        = 1'b0;
    mem_read           = 1'b0;
    unique case (state_q)
      SAVE: begin
        epc_write   = 1'b1;
        mem_vec_sel = 1'b1;
        mem_read    = 1'b1;
      end
      WAIT: begin
        mem_vec_sel = 1'b1;
        mem_read    = 1'b1;
      end
      LOAD: pc_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: MEM_LATENCY=1, instance 1: MEM_LATENCY=3.
  logic [1:0]  rst_n = 2'b11;
  logic [1:0]  f_op = '0, f_ov = '0, f_dz = '0;
  logic [31:0] pc_in [2];
  logic [31:0] mem_d [2];
  wire  [1:0]  ctrl [2];
  wire  [31:0] epc_o [2];
  wire  [31:0] pc_o [2];
  wire  [1:0]  mvs, mrd, epc_we, pc_we, busy, df;

  exception_sequencer #(.MEM_LATENCY(1), .EPC_OFFSET(4)) dut0 (
    .clk(clk), .reset(rst_n[0]), .exc_opcode(f_op[0]), .exc_overflow(f_ov[0]),
    .exc_divzero(f_dz[0]), .pc_in(pc_in[0]), .mem_data_in(mem_d[0]),
    .exceptions_control(ctrl[0]), .mem_vec_sel(mvs[0]), .mem_read(mrd[0]),
    .epc_out(epc_o[0]), .epc_write(epc_we[0]), .pc_out(pc_o[0]), .pc_write(pc_we[0]),
    .busy(busy[0]), .double_fault(df[0])
  );

  exception_sequencer #(.MEM_LATENCY(3), .EPC_OFFSET(4)) dut1 (
    .clk(clk), .reset(rst_n[1]), .exc_opcode(f_op[1]), .exc_overflow(f_ov[1]),
    .exc_divzero(f_dz[1]), .pc_in(pc_in[1]), .mem_data_in(mem_d[1]),
    .exceptions_control(ctrl[1]), .mem_vec_sel(mvs[1]), .mem_read(mrd[1]),
    .epc_out(epc_o[1]), .epc_write(epc_we[1]), .pc_out(pc_o[1]), .pc_write(pc_we[1]),
    .busy(busy[1]), .double_fault(df[1])
  );

  typedef struct {
    int          inst;
    bit          is_pc;
    logic [31:0] val;
    logic [1:0]  cause;
  } ev_t;

  ev_t        sb[$];
  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_cause [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT strobes a register write.
  always @(negedge clk) begin
    ev_t ev;
    for (int i = 0; i < 2; i++) begin
      if (epc_we[i] === 1'b1) begin
        if (sb.size() == 0 || sb[0].inst != i || sb[0].is_pc) begin
          total++; bad++;
          $display("FAIL unexpected_epc_write: inst %0d got epc %h expected none", i, epc_o[i]);
        end else begin
          ev = sb.pop_front();
          chk("epc_out", epc_o[i], ev.val);
          chk("cause_at_save", {30'b0, ctrl[i]}, {30'b0, ev.cause});
          exp_cause[i] = ev.cause;
        end
      end
      if (pc_we[i] === 1'b1) begin
        if (sb.size() == 0 || sb[0].inst != i || !sb[0].is_pc) begin
          total++; bad++;
          $display("FAIL unexpected_pc_write: inst %0d got pc %h expected none", i, pc_o[i]);
        end else begin
          ev = sb.pop_front();
          chk("pc_out", pc_o[i], ev.val);
        end
      end
      if (mrd[i] === 1'b1) begin
        chk("mem_vec_sel", {31'b0, mvs[i]}, 32'd1);
        chk("cause_while_read", {30'b0, ctrl[i]}, {30'b0, exp_cause[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input int i, input logic [31:0] epc, input logic [1:0] cause,
                            input logic [31:0] pc, input bit completes);
    ev_t e;
    e.inst = i; e.is_pc = 1'b0; e.val = epc; e.cause = cause;
    sb.push_back(e);
    if (completes) begin
      e.is_pc = 1'b1; e.val = pc;
      sb.push_back(e);
    end
  endtask

  // Flags held for one cycle; returns one cycle later (SAVE cycle).
  task automatic pulse(input int i, input bit op, input bit ov, input bit dz,
                       input logic [31:0] pc);
    f_op[i] = op; f_ov[i] = ov; f_dz[i] = dz; pc_in[i] = pc;
    tick();
    f_op[i] = 1'b0; f_ov[i] = 1'b0; f_dz[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk);
    while (busy[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy[i] !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: inst %0d busy %b expected 0", i, busy[i]);
    end
    tick();
  endtask

  task automatic chk_reset_outs(input int i);
    chk("rst_ctrl", {30'b0, ctrl[i]}, 32'd0);
    chk("rst_epc", epc_o[i], 32'd0);
    chk("rst_pc", pc_o[i], 32'd0);
    chk("rst_busy", {31'b0, busy[i]}, 32'd0);
    chk("rst_df", {31'b0, df[i]}, 32'd0);
    chk("rst_mem_read", {31'b0, mrd[i]}, 32'd0);
    chk("rst_pc_write", {31'b0, pc_we[i]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pc_in[i] = '0; mem_d[i] = '0; exp_cause[i] = '0;
    end
    #2 rst_n = 2'b00;
    #1;
    chk_reset_outs(0);
    chk_reset_outs(1);
    tick();
    rst_n = 2'b11;
    tick();

    // Overflow, pc 0x40: EPC 0x3C, handler 0xA8, timing per cycle.
    mem_d[0] = 32'h0000_00A8;
    expect_seq(0, 32'h0000_003C, 2'd1, 32'h0000_00A8, 1'b1);
    pulse(0, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
    @(negedge clk);
    chk("save_epc_write", {31'b0, epc_we[0]}, 32'd1);
    chk("save_busy", {31'b0, busy[0]}, 32'd1);
    @(negedge clk);
    chk("wait_mem_read", {31'b0, mrd[0]}, 32'd1);
    chk("wait_no_pc_write", {31'b0, pc_we[0]}, 32'd0);
    @(negedge clk);
    chk("load_pc_write", {31'b0, pc_we[0]}, 32'd1);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy[0]}, 32'd0);
    chk("idle_hold_pc", pc_o[0], 32'h0000_00A8);
    tick();

    // All three flags: opcode wins.
    mem_d[0] = 32'hFFFF_FF55;
    expect_seq(0, 32'h0000_00FC, 2'd0, 32'h0000_0055, 1'b1);
    pulse(0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    wait_idle(0);
    chk("no_double_fault", {31'b0, df[0]}, 32'd0);

    // Divzero at pc 0 wraps EPC.
    mem_d[0] = 32'h0000_0077;
    expect_seq(0, 32'hFFFF_FFFC, 2'd2, 32'h0000_0077, 1'b1);
    pulse(0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    wait_idle(0);

    // Flag in first IDLE cycle after LOAD starts a fresh sequence.
    mem_d[0] = 32'h0000_0011;
    expect_seq(0, 32'h0000_002C, 2'd1, 32'h0000_0011, 1'b1);
    expect_seq(0, 32'h0000_005C, 2'd2, 32'h0000_0011, 1'b1);
    pulse(0, 1'b0, 1'b1, 1'b0, 32'h0000_0030); // now SAVE
    tick();                                      // WAIT
    tick();                                      // LOAD
    tick();                                      // IDLE
    pulse(0, 1'b0, 1'b0, 1'b1, 32'h0000_0060);
    wait_idle(0);
    chk("back_to_back_no_df", {31'b0, df[0]}, 32'd0);

    // Opcode during WAIT of overflow sequence: ignored, sets sticky double fault.
    mem_d[0] = 32'h0000_0099;
    expect_seq(0, 32'h0000_01FC, 2'd1, 32'h0000_0099, 1'b1);
    pulse(0, 1'b0, 1'b1, 1'b0, 32'h0000_0200); // now SAVE
    tick();                                      // WAIT
    f_op[0] = 1'b1;
    tick();
    f_op[0] = 1'b0;
    wait_idle(0);
    chk("double_fault_set", {31'b0, df[0]}, 32'd1);
    tick(); tick(); tick();
    chk("double_fault_sticky", {31'b0, df[0]}, 32'd1);
    chk("df_idle_busy", {31'b0, busy[0]}, 32'd0);
    rst_n[0] = 1'b0;
    #1;
    chk("double_fault_cleared", {31'b0, df[0]}, 32'd0);
    tick();
    rst_n[0] = 1'b1;
    tick();

    // Latency 3: reset during WAIT aborts with no pc_write.
    expect_seq(1, 32'h0000_03FC, 2'd2, 32'h0, 1'b0);
    pulse(1, 1'b0, 1'b0, 1'b1, 32'h0000_0400); // SAVE
    tick();                                      // WAIT
    chk("abort_in_wait", {31'b0, mrd[1]}, 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk_reset_outs(1);
    tick(); tick(); tick();
    rst_n[1] = 1'b1;
    tick();

    // Latency 3 with changing data: byte of third WAIT cycle is loaded.
    expect_seq(1, 32'h0000_07FC, 2'd1, 32'h0000_0014, 1'b1);
    mem_d[1] = 32'hDEAD_BE10;
    pulse(1, 1'b0, 1'b1, 1'b0, 32'h0000_0800);
    for (int j = 1; j <= 6; j++) begin
      mem_d[1] = 32'hDEAD_BE00 | (32'h10 + 32'(j));
      tick();
    end
    wait_idle(1);
    chk("l3_df_clear", {31'b0, df[1]}, 32'd0);

    tick(); tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Raising end of the exception interface: takes one-cycle exception flags from the control unit, picks the winning cause and saves EPC.
- Drives the 2-bit cause code to the vector-address mapper, which produces vector byte addresses 253/254/255.
- Fetches the handler byte from memory and loads it into PC.
- Sits between control unit, PC/EPC registers and memory address mux; stalls the main FSM via busy.

Parameters:
- MEM_LATENCY, 1, memory read wait cycles (>=1) between address presentation and valid mem_data_in.
- EPC_OFFSET, 4, value subtracted from pc_in to form EPC.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- exc_opcode  in  1  invalid-opcode flag
- exc_overflow  in  1  arithmetic overflow flag
- exc_divzero  in  1  divide-by-zero flag
- pc_in  in  32  current (already incremented) PC
- mem_data_in  in  32  memory read data; byte [7:0] is the handler address
- exceptions_control  out  2  cause code to vector mapper: 0 opcode, 1 overflow, 2 divzero
- mem_vec_sel  out  1  memory address mux selects vector address
- mem_read  out  1  memory read strobe
- epc_out  out  32  EPC value
- epc_write  out  1  EPC register write enable
- pc_out  out  32  new PC value
- pc_write  out  1  PC write enable
- busy  out  1  sequence in progress; main FSM must stall
- double_fault  out  1  sticky: exception raised while busy

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0: exceptions_control=0, epc_out=0, pc_out=0, busy=0, double_fault=0. Counter cleared. Reset mid-sequence aborts immediately; no pc_write is issued.
- Priority on simultaneous flags: opcode > overflow > divzero. Code 3 is never driven.
- States: IDLE, SAVE, WAIT, LOAD.
- IDLE: busy=0, all strobes 0. On a clock edge with any flag set:
  - cause_q <= encoded cause.
  - epc_q <= pc_in - EPC_OFFSET, mod 2^32 (pc_in=0 gives 0xFFFFFFFC).
  - counter <= MEM_LATENCY; next state SAVE.
- SAVE (1 cycle):
  - epc_write=1, epc_out=epc_q.
  - mem_vec_sel=1, mem_read=1, exceptions_control=cause_q, busy=1.
  - Next state WAIT.
- WAIT (MEM_LATENCY cycles):
  - mem_vec_sel=1, mem_read=1, exceptions_control=cause_q, busy=1.
  - counter decrements each cycle. When it reaches 0 on an edge: latch pc_q <= {24'b0, mem_data_in[7:0]}, next state LOAD.
- LOAD (1 cycle): pc_write=1, pc_out=pc_q, busy=1; next state IDLE.
- Latency: flags sampled at edge k; epc_write in cycle k+1; pc_write in cycle k+2+MEM_LATENCY; busy low from cycle k+3+MEM_LATENCY.
- epc_out, pc_out and exceptions_control hold their last values in IDLE; strobes are pulses only.
- Flags while not IDLE are ignored for sequencing. Any such flag sets double_fault; it stays set until reset.
- A flag on the LOAD cycle is a double fault. A flag in the first IDLE cycle after LOAD starts a new sequence.
- All outputs are Moore decodes of state and registers; no combinational input-to-output path.

Decomposition:
- Shared package:
  - cause codes EXC_OPCODE=2'd0, EXC_OVERFLOW=2'd1, EXC_DIVZERO=2'd2.
  - vector addresses VEC_OPCODE=32'd253, VEC_OVERFLOW=32'd254, VEC_DIVZERO=32'd255.
  - state enum exc_state_t {IDLE, SAVE, WAIT, LOAD}.
- Sub-module exc_priority_encoder: combinational. Three flags in; valid plus 2-bit cause out. Reused by the vector mapper's checker.

Test Plan:
- exc_overflow pulse, pc_in=0x00000040, MEM_LATENCY=1, mem_data_in=0x000000A8 -> epc_write with epc_out=0x0000003C next cycle; exceptions_control=1 while mem_read; pc_write with pc_out=0x000000A8 three cycles after the pulse; busy returns to 0.
- exc_opcode, exc_overflow and exc_divzero together -> exceptions_control=0, vector 253 path; other causes dropped; double_fault stays 0.
- exc_divzero with pc_in=0x00000000 -> epc_out=0xFFFFFFFC, exceptions_control=2.
- exc_opcode during WAIT of an overflow sequence -> sequence completes with cause 1 unchanged; double_fault=1 and stays 1 until reset.
- reset pulled low during WAIT -> all outputs 0 immediately; no pc_write; next exception runs a full clean sequence.
- MEM_LATENCY=3, mem_data_in changing each cycle -> pc_out equals the byte present on the third WAIT cycle.
